idle_pattern_gen: RTL and testbench

IDLE_PATTERN_GEN -- requirements
Module: idle_pattern_gen

---
 rtl/iso_pkg.sv | 18 +
 rtl/idle_pattern_gen.sv | 101 ++++++++++
 tb/tb_idle_pattern_gen.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/iso_pkg.sv
// Shared link-layer symbol constants and the idle-pattern state encoding.
package iso_pkg;

  localparam logic [7:0] K_BS          = 8'hBC;
  localparam logic [7:0] K_SR          = 8'h1C;
  localparam logic [7:0] VBID_NO_VIDEO = 8'h09;
  localparam logic [7:0] DUMMY_SYM     = 8'h00;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_BS,
    ST_VBID,
    ST_MVID,
    ST_MAUD,
    ST_DUMMY
  } idle_state_e;

endpackage

// File: rtl/idle_pattern_gen.sv
// Idle-pattern generator: BS/SR, VBID, MVID, MAUD, then DUMMY fill, repeating every IDLE_PERIOD symbols.
// Registered outputs, one cycle behind the state; dropping idle_en parks the block in ST_OFF at once.
module idle_pattern_gen
  import iso_pkg::*;
#(
  parameter int IDLE_PERIOD = 8192,
  parameter int SR_INTERVAL = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       idle_en,
  output logic [7:0] idle_symbols,
  output logic       idle_control_sym_flag,
  output logic       idle_bs_pulse
);

  localparam int CW = (IDLE_PERIOD > 1) ? $clog2(IDLE_PERIOD) : 1;
  localparam int BW = (SR_INTERVAL > 1) ? $clog2(SR_INTERVAL) : 1;

  generate
    if (IDLE_PERIOD < 5) begin : g_bad_period
      $error("idle_pattern_gen: IDLE_PERIOD must be at least 5");
    end
    if (SR_INTERVAL < 1) begin : g_bad_interval
      $error("idle_pattern_gen: SR_INTERVAL must be at least 1");
    end
  endgenerate

  idle_state_e     r_state;
  logic [CW-1:0]   r_sym_cnt;
  logic [BW-1:0]   r_bs_cnt;
  logic [7:0]      r_sym;
  logic            r_k;
  logic            r_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_OFF;
      r_sym_cnt <= '0;
      r_bs_cnt  <= '0;
      r_sym     <= DUMMY_SYM;
      r_k       <= 1'b0;
      r_pulse   <= 1'b0;
    end else if (!idle_en) begin
      // bs_cnt is kept so the SR cadence survives idle gaps
      r_state   <= ST_OFF;
      r_sym_cnt <= '0;
      r_sym     <= DUMMY_SYM;
      r_k       <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_sym   <= DUMMY_SYM;
      r_k     <= 1'b0;
      r_pulse <= 1'b0;
      case (r_state)
        ST_OFF: begin
          r_state   <= ST_BS;
          r_sym_cnt <= '0;
        end
        ST_BS: begin
          r_sym     <= (r_bs_cnt == '0) ? K_SR : K_BS;
          r_k       <= 1'b1;
          r_pulse   <= 1'b1;
          r_bs_cnt  <= (r_bs_cnt == BW'(SR_INTERVAL - 1)) ? '0 : r_bs_cnt + BW'(1);
          r_sym_cnt <= r_sym_cnt + CW'(1);
          r_state   <= ST_VBID;
        end
        ST_VBID: begin
          r_sym     <= VBID_NO_VIDEO;
          r_sym_cnt <= r_sym_cnt + CW'(1);
          r_state   <= ST_MVID;
        end
        ST_MVID: begin
          r_sym_cnt <= r_sym_cnt + CW'(1);
          r_state   <= ST_MAUD;
        end
        ST_MAUD: begin
          r_sym_cnt <= r_sym_cnt + CW'(1);
          r_state   <= ST_DUMMY;
        end
        ST_DUMMY: begin
          if (r_sym_cnt == CW'(IDLE_PERIOD - 1)) begin
            r_sym_cnt <= '0;
            r_state   <= ST_BS;
          end else begin
            r_sym_cnt <= r_sym_cnt + CW'(1);
          end
        end
        default: begin
          r_state   <= ST_OFF;
          r_sym_cnt <= '0;
        end
      endcase
    end
  end

  assign idle_symbols          = r_sym;
  assign idle_control_sym_flag = r_k;
  assign idle_bs_pulse         = r_pulse;

endmodule

// File: tb/tb_idle_pattern_gen.sv
// Randomized check of idle_pattern_gen against a period/position model, plus directed literal checks.
module tb_idle_pattern_gen;

  localparam int P  = 16;
  localparam int SR = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       idle_en = 1'b0;
  logic       idle_en_def = 1'b0;
  logic [7:0] sym, sym_d;
  logic       k, k_d, pul, pul_d;

  always #5 clk = ~clk;

  idle_pattern_gen #(.IDLE_PERIOD(P), .SR_INTERVAL(SR)) dut (
    .clk(clk), .rst_n(rst_n), .idle_en(idle_en),
    .idle_symbols(sym), .idle_control_sym_flag(k), .idle_bs_pulse(pul)
  );

  idle_pattern_gen dut_def (
    .clk(clk), .rst_n(rst_n), .idle_en(idle_en_def),
    .idle_symbols(sym_d), .idle_control_sym_flag(k_d), .idle_bs_pulse(pul_d)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [7:0] s, input logic kk, input logic pp,
                       input logic [7:0] es, input logic ek, input logic ep);
    n_tests++;
    if (s !== es || kk !== ek || pp !== ep) begin
      n_fail++;
      $display("FAIL %s @%0t: got sym=%h k=%b pulse=%b, expected sym=%h k=%b pulse=%b",
               name, $time, s, kk, pp, es, ek, ep);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  // Model: run = consecutive enabled edges since last low/reset; the first only arms,
  // then position (run-1) mod P selects blanking start / VBID / zero fill.
  int         run = 0;
  int         nblank = 0;
  logic [7:0] e_sym;
  logic       e_k, e_p;

  initial begin
    forever begin
      @(posedge clk);
      e_sym = 8'h00; e_k = 1'b0; e_p = 1'b0;
      if (!rst_n) begin
        run = 0; nblank = 0;
      end else if (!idle_en) begin
        run = 0;
      end else begin
        if (run > 0) begin
          int q;
          q = (run - 1) % P;
          if (q == 0) begin
            e_sym = (nblank % SR == 0) ? 8'h1C : 8'hBC;
            e_k = 1'b1; e_p = 1'b1;
            nblank++;
          end else if (q == 1) begin
            e_sym = 8'h09;
          end
        end
        run++;
      end
      #1;
      check("model", sym, k, pul, e_sym, e_k, e_p);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic v);
    @(negedge clk);
    idle_en = v;
  endtask

  initial begin
    int gap, zeros;

    repeat (3) @(posedge clk);
    #1;
    check("reset", sym, k, pul, 8'h00, 1'b0, 1'b0);
    check("reset_def", sym_d, k_d, pul_d, 8'h00, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    idle_en = 1'b1;
    tick(); check("c0_arm", sym, k, pul, 8'h00, 1'b0, 1'b0);
    tick(); check("c1_sr",  sym, k, pul, 8'h1C, 1'b1, 1'b1);
    tick(); check("c2_vbid", sym, k, pul, 8'h09, 1'b0, 1'b0);
    tick(); check("c3_mvid", sym, k, pul, 8'h00, 1'b0, 1'b0);
    tick(); check("c4_maud", sym, k, pul, 8'h00, 1'b0, 1'b0);
    repeat (12) tick();
    tick(); check("c17_bs", sym, k, pul, 8'hBC, 1'b1, 1'b1);

    // blanking starts 3..9: spacing, fill count, SR returns on the (SR+1)th
    for (int i = 3; i <= SR + 1; i++) begin
      gap = 0; zeros = 0;
      do begin
        tick();
        gap++;
        if (!pul && !k && sym == 8'h00) zeros++;
      end while (!pul && gap < 100);
      check_int("bs_spacing", gap, P);
      check_int("zero_fill", zeros, P - 2);
      if (i == SR + 1) check("sr_wrap", sym, k, pul, 8'h1C, 1'b1, 1'b1);
      else             check("bs_mid",  sym, k, pul, 8'hBC, 1'b1, 1'b1);
    end

    // drop mid-period for 3 edges, then restart from a BS (bs_cnt retained)
    repeat (9) tick();
    set_en(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); check("gap_low", sym, k, pul, 8'h00, 1'b0, 1'b0);
    end
    set_en(1'b1);
    tick(); check("resume_arm", sym, k, pul, 8'h00, 1'b0, 1'b0);
    tick(); check("resume_bs", sym, k, pul, 8'hBC, 1'b1, 1'b1);

    // asynchronous reset while a BS is on the outputs
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", sym, k, pul, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); check("post_rst_arm", sym, k, pul, 8'h00, 1'b0, 1'b0);
    tick(); check("post_rst_sr", sym, k, pul, 8'h1C, 1'b1, 1'b1);

    // randomized enable and occasional reset, checked by the model each cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      idle_en = ($urandom_range(0, 199) >= ((i < 1500) ? 20 : 2));
      rst_n   = ($urandom_range(0, 999) >= 3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_en = 1'b0;

    // default parameters: SR at cycle 1, BS again at cycle 8193
    @(negedge clk);
    idle_en_def = 1'b1;
    tick(); check("def_c0", sym_d, k_d, pul_d, 8'h00, 1'b0, 1'b0);
    tick(); check("def_c1", sym_d, k_d, pul_d, 8'h1C, 1'b1, 1'b1);
    tick(); check("def_c2", sym_d, k_d, pul_d, 8'h09, 1'b0, 1'b0);
    tick(); check("def_c3", sym_d, k_d, pul_d, 8'h00, 1'b0, 1'b0);
    tick(); check("def_c4", sym_d, k_d, pul_d, 8'h00, 1'b0, 1'b0);
    repeat (8187) tick();
    tick(); check("def_c8192", sym_d, k_d, pul_d, 8'h00, 1'b0, 1'b0);
    tick(); check("def_c8193", sym_d, k_d, pul_d, 8'hBC, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
